// File: rtl/branch_predict_unit_pkg.sv
// Shared branch codes and BHT helpers for the RV32I branch unit.
// Nine control-flow codes (including JALR) need a 4-bit branch code.
package branch_predict_unit_pkg;

  localparam int BR_W = 4;

  localparam logic [BR_W-1:0] BR_NONE = 4'd0;
  localparam logic [BR_W-1:0] BR_BEQ  = 4'd1;
  localparam logic [BR_W-1:0] BR_BNE  = 4'd2;
  localparam logic [BR_W-1:0] BR_BLT  = 4'd3;
  localparam logic [BR_W-1:0] BR_BGE  = 4'd4;
  localparam logic [BR_W-1:0] BR_BLTU = 4'd5;
  localparam logic [BR_W-1:0] BR_BGEU = 4'd6;
  localparam logic [BR_W-1:0] BR_JAL  = 4'd7;
  localparam logic [BR_W-1:0] BR_JALR = 4'd8;

  localparam logic [1:0] BHT_INIT = 2'b01;

  // Saturating 2-bit counter step: up on taken, down on not taken.
  function automatic logic [1:0] bht_train(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) nxt = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) nxt = ctr - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluation for the EX stage.
module branch_compare
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [BR_W-1:0] ex_br,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (ex_br)
      BR_BEQ:  taken = (rs1 == rs2);
      BR_BNE:  taken = (rs1 != rs2);
      BR_BLT:  taken = ($signed(rs1) < $signed(rs2));
      BR_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      BR_BLTU: taken = (rs1 < rs2);
      BR_BGEU: taken = (rs1 >= rs2);
      BR_JAL:  taken = 1'b1;
      BR_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch unit: BHT + tagged BTB prediction at IF, resolution, redirect and
// table training at EX, plus branch / misprediction performance counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 pred_taken,
  output logic [XLEN-1:0]      pred_target,
  input  logic                 ex_valid,
  input  logic                 ex_stall,
  input  logic [BR_W-1:0]      ex_br,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [XLEN-1:0]      ex_rs1,
  input  logic [XLEN-1:0]      ex_rs2,
  input  logic [XLEN-1:0]      ex_imm,
  input  logic                 ex_pred_taken,
  input  logic [XLEN-1:0]      ex_pred_target,
  output logic                 redirect,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] mispred_count
);

  localparam int BHT_IW = $clog2(BHT_ENTRIES);
  localparam int BTB_IW = $clog2(BTB_ENTRIES);
  localparam int TAG_W  = XLEN - BTB_IW - 2;
  localparam logic [XLEN-1:0]      PC_STEP = XLEN'(4);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [1:0]       bht        [BHT_ENTRIES];
  logic             btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_target [BTB_ENTRIES];
  logic             btb_jump   [BTB_ENTRIES];

  // IF-side lookup reads the arrays as they stand; same-cycle writes are not bypassed.
  logic [BHT_IW-1:0] if_bht_idx;
  logic [BTB_IW-1:0] if_btb_idx;
  logic [TAG_W-1:0]  if_tag;
  logic              if_hit;

  assign if_bht_idx  = if_pc[BHT_IW+1:2];
  assign if_btb_idx  = if_pc[BTB_IW+1:2];
  assign if_tag      = if_pc[XLEN-1:BTB_IW+2];
  assign if_hit      = btb_valid[if_btb_idx] && (btb_tag[if_btb_idx] == if_tag);
  assign pred_taken  = if_hit && (btb_jump[if_btb_idx] || bht[if_bht_idx][1]);
  assign pred_target = pred_taken ? btb_target[if_btb_idx] : (if_pc + PC_STEP);

  logic              ex_taken;
  logic              ex_active;
  logic              ex_is_cond;
  logic              ex_is_jump;
  logic              ex_mispred;
  logic [XLEN-1:0]   ex_jalr_sum;
  logic [XLEN-1:0]   ex_target;
  logic [XLEN-1:0]   ex_fallthru;
  logic [BHT_IW-1:0] ex_bht_idx;
  logic [BTB_IW-1:0] ex_btb_idx;
  logic [TAG_W-1:0]  ex_tag;

  branch_compare #(.XLEN(XLEN)) u_compare (
    .ex_br (ex_br),
    .rs1   (ex_rs1),
    .rs2   (ex_rs2),
    .taken (ex_taken)
  );

  // Codes above BR_JALR are undefined and treated like BR_NONE.
  assign ex_active   = ex_valid && !ex_stall && (ex_br != BR_NONE) && (ex_br <= BR_JALR);
  assign ex_is_jump  = (ex_br == BR_JAL) || (ex_br == BR_JALR);
  assign ex_is_cond  = (ex_br >= BR_BEQ) && (ex_br <= BR_BGEU);
  assign ex_jalr_sum = ex_rs1 + ex_imm;
  assign ex_target   = (ex_br == BR_JALR) ? {ex_jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
  assign ex_fallthru = ex_pc + PC_STEP;
  assign ex_mispred  = (ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target));
  assign redirect    = ex_active && ex_mispred;
  assign redirect_pc = (ex_active && ex_taken) ? ex_target : ex_fallthru;

  assign ex_bht_idx  = ex_pc[BHT_IW+1:2];
  assign ex_btb_idx  = ex_pc[BTB_IW+1:2];
  assign ex_tag      = ex_pc[XLEN-1:BTB_IW+2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= BHT_INIT;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_jump[i]   <= 1'b0;
      end
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (ex_active) begin
        br_count <= br_count + CNT_ONE;
        if (ex_is_cond) bht[ex_bht_idx] <= bht_train(bht[ex_bht_idx], ex_taken);
        // Only taken instructions allocate; a not-taken branch leaves its entry alone.
        if (ex_taken) begin
          btb_valid[ex_btb_idx]  <= 1'b1;
          btb_tag[ex_btb_idx]    <= ex_tag;
          btb_target[ex_btb_idx] <= ex_target;
          btb_jump[ex_btb_idx]   <= ex_is_jump;
        end
      end
      if (redirect) mispred_count <= mispred_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus a
// randomized run against a behavioural model of the prediction tables.
module tb_branch_predict_unit;
  import branch_predict_unit_pkg::*;

  localparam int XLEN  = 32;
  localparam int BHT_N = 64;
  localparam int BTB_N = 16;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic [XLEN-1:0]  if_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             ex_valid;
  logic             ex_stall;
  logic [BR_W-1:0]  ex_br;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_rs1;
  logic [XLEN-1:0]  ex_rs2;
  logic [XLEN-1:0]  ex_imm;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;
  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  int n_checks = 0;
  int n_errors = 0;

  branch_predict_unit #(
    .XLEN(XLEN), .BHT_ENTRIES(BHT_N), .BTB_ENTRIES(BTB_N), .CNT_WIDTH(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_br(ex_br), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_bht   [BHT_N];
  bit          m_valid [BTB_N];
  logic [31:0] m_owner [BTB_N];
  logic [31:0] m_tgt   [BTB_N];
  bit          m_jump  [BTB_N];
  logic [31:0] m_br_cnt;
  logic [31:0] m_mis_cnt;

  function automatic void model_reset();
    for (int i = 0; i < BHT_N; i++) m_bht[i] = 1;
    for (int i = 0; i < BTB_N; i++) begin
      m_valid[i] = 0; m_owner[i] = 0; m_tgt[i] = 0; m_jump[i] = 0;
    end
    m_br_cnt = 0;
    m_mis_cnt = 0;
  endfunction

  function automatic int btb_slot(logic [31:0] pc);
    return int'((pc / 4) % BTB_N);
  endfunction

  function automatic int bht_slot(logic [31:0] pc);
    return int'((pc / 4) % BHT_N);
  endfunction

  function automatic bit model_pred_taken(logic [31:0] pc);
    int s;
    bit hit;
    s = btb_slot(pc);
    hit = m_valid[s] && ((m_owner[s] / (4 * BTB_N)) == (pc / (4 * BTB_N)));
    return hit && (m_jump[s] || m_bht[bht_slot(pc)] >= 2);
  endfunction

  function automatic logic [31:0] model_pred_target(logic [31:0] pc);
    return model_pred_taken(pc) ? m_tgt[btb_slot(pc)] : pc + 32'd4;
  endfunction

  function automatic bit model_taken(logic [3:0] br, logic [31:0] a, logic [31:0] b);
    case (br)
      BR_BEQ:  return a == b;
      BR_BNE:  return a != b;
      BR_BLT:  return $signed(a) < $signed(b);
      BR_BGE:  return $signed(a) >= $signed(b);
      BR_BLTU: return a < b;
      BR_BGEU: return a >= b;
      BR_JAL, BR_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_target(logic [3:0] br, logic [31:0] pc,
                                               logic [31:0] a, logic [31:0] imm);
    if (br == BR_JALR) return (a + imm) & 32'hFFFF_FFFE;
    return pc + imm;
  endfunction

  function automatic bit model_active();
    return ex_valid && !ex_stall && ex_br != BR_NONE;
  endfunction

  function automatic bit model_redirect();
    bit t;
    logic [31:0] tg;
    if (!model_active()) return 1'b0;
    t  = model_taken(ex_br, ex_rs1, ex_rs2);
    tg = model_target(ex_br, ex_pc, ex_rs1, ex_imm);
    return (t != ex_pred_taken) || (t && tg != ex_pred_target);
  endfunction

  function automatic logic [31:0] model_redirect_pc();
    if (model_active() && model_taken(ex_br, ex_rs1, ex_rs2))
      return model_target(ex_br, ex_pc, ex_rs1, ex_imm);
    return ex_pc + 32'd4;
  endfunction

  function automatic void model_commit();
    bit t;
    int s;
    if (!model_active()) return;
    t = model_taken(ex_br, ex_rs1, ex_rs2);
    m_br_cnt = m_br_cnt + 1;
    if (model_redirect()) m_mis_cnt = m_mis_cnt + 1;
    if (ex_br >= BR_BEQ && ex_br <= BR_BGEU) begin
      s = bht_slot(ex_pc);
      if (t && m_bht[s] < 3) m_bht[s]++;
      else if (!t && m_bht[s] > 0) m_bht[s]--;
    end
    if (t) begin
      s = btb_slot(ex_pc);
      m_valid[s] = 1;
      m_owner[s] = ex_pc;
      m_tgt[s]   = model_target(ex_br, ex_pc, ex_rs1, ex_imm);
      m_jump[s]  = (ex_br == BR_JAL || ex_br == BR_JALR);
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; leaves 1 time unit for outputs to settle.
  task automatic drive(input bit v, input bit st, input logic [3:0] br,
                       input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input bit pt, input logic [31:0] ptgt);
    ex_valid = v; ex_stall = st; ex_br = br; ex_pc = pc;
    ex_rs1 = a; ex_rs2 = b; ex_imm = imm;
    ex_pred_taken = pt; ex_pred_target = ptgt;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, BR_NONE, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h4);
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    if_pc = 32'h100;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_errors++; $display("FAIL reset_pred_taken: got %0b expected 0", pred_taken);
    end
    n_checks++;
    if (pred_target !== 32'h104) begin
      n_errors++; $display("FAIL reset_pred_target: got %h expected 00000104", pred_target);
    end
    n_checks++;
    if (br_count !== 32'd0 || mispred_count !== 32'd0) begin
      n_errors++; $display("FAIL reset_counters: got br=%0d mis=%0d expected 0 0", br_count, mispred_count);
    end
    n_checks++;
    if (redirect !== 1'b0) begin
      n_errors++; $display("FAIL reset_redirect: got %0b expected 0", redirect);
    end
  endtask

  task automatic test_beq_train();
    if_pc = 32'h100;
    drive(1, 0, BR_BEQ, 32'h100, 32'd5, 32'd5, 32'h40, 0, 32'h104);
    n_checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h140) begin
      n_errors++; $display("FAIL beq_first: got redirect=%0b pc=%h expected 1 00000140", redirect, redirect_pc);
    end
    tick();
    idle();
    n_checks++;
    if (mispred_count !== 32'd1 || br_count !== 32'd1) begin
      n_errors++; $display("FAIL beq_first_counts: got br=%0d mis=%0d expected 1 1", br_count, mispred_count);
    end
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h140) begin
      n_errors++; $display("FAIL beq_predict_after_train: got %0b %h expected 1 00000140", pred_taken, pred_target);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, BR_BEQ, 32'h100, 32'd5, 32'd5, 32'h40, 1, 32'h140);
      n_checks++;
      if (redirect !== 1'b0) begin
        n_errors++; $display("FAIL beq_correct_%0d: got redirect=%0b expected 0", k, redirect);
      end
      tick();
    end
    drive(1, 0, BR_BEQ, 32'h100, 32'd1, 32'd2, 32'h40, 1, 32'h140);
    n_checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h104) begin
      n_errors++; $display("FAIL beq_not_taken: got redirect=%0b pc=%h expected 1 00000104", redirect, redirect_pc);
    end
    tick();
    idle();
    // Counter went 3 -> 2: still predicted taken, BTB entry kept.
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h140) begin
      n_errors++; $display("FAIL beq_retained: got %0b %h expected 1 00000140", pred_taken, pred_target);
    end
    drive(1, 0, BR_BEQ, 32'h100, 32'd1, 32'd2, 32'h40, 1, 32'h140);
    tick();
    idle();
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      n_errors++; $display("FAIL beq_weak_not_taken: got %0b %h expected 0 00000104", pred_taken, pred_target);
    end
    n_checks++;
    if (br_count !== 32'd6 || mispred_count !== 32'd3) begin
      n_errors++; $display("FAIL beq_counts: got br=%0d mis=%0d expected 6 3", br_count, mispred_count);
    end
  endtask

  task automatic test_signed_unsigned();
    drive(1, 0, BR_BLT, 32'h600, 32'hFFFF_FFFF, 32'd1, 32'h20, 0, 32'h604);
    n_checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h620) begin
      n_errors++; $display("FAIL blt_signed: got redirect=%0b pc=%h expected 1 00000620", redirect, redirect_pc);
    end
    tick();
    drive(1, 0, BR_BLTU, 32'h700, 32'hFFFF_FFFF, 32'd1, 32'h20, 0, 32'h704);
    n_checks++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h704) begin
      n_errors++; $display("FAIL bltu_unsigned: got redirect=%0b pc=%h expected 0 00000704", redirect, redirect_pc);
    end
    tick();
    drive(1, 0, BR_BLTU, 32'h700, 32'hFFFF_FFFF, 32'd1, 32'h20, 1, 32'h720);
    n_checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h704) begin
      n_errors++; $display("FAIL bltu_mispred: got redirect=%0b pc=%h expected 1 00000704", redirect, redirect_pc);
    end
    tick();
    drive(1, 0, BR_BGE, 32'h640, 32'hFFFF_FFFF, 32'd1, 32'h20, 1, 32'h660);
    n_checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h644) begin
      n_errors++; $display("FAIL bge_signed: got redirect=%0b pc=%h expected 1 00000644", redirect, redirect_pc);
    end
    tick();
    idle();
    n_checks++;
    if (br_count !== m_br_cnt || mispred_count !== m_mis_cnt) begin
      n_errors++; $display("FAIL cmp_counts: got br=%0d mis=%0d expected %0d %0d", br_count, mispred_count, m_br_cnt, m_mis_cnt);
    end
  endtask

  task automatic test_jalr();
    drive(1, 0, BR_JALR, 32'h500, 32'h2001, 32'h0, 32'h10, 1, 32'h2010);
    n_checks++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h2010) begin
      n_errors++; $display("FAIL jalr_correct: got redirect=%0b pc=%h expected 0 00002010", redirect, redirect_pc);
    end
    tick();
    drive(1, 0, BR_JALR, 32'h500, 32'h2001, 32'h0, 32'h10, 1, 32'h3000);
    n_checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h2010) begin
      n_errors++; $display("FAIL jalr_wrong_target: got redirect=%0b pc=%h expected 1 00002010", redirect, redirect_pc);
    end
    tick();
    if_pc = 32'h500;
    idle();
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h2010) begin
      n_errors++; $display("FAIL jalr_btb_jump: got %0b %h expected 1 00002010", pred_taken, pred_target);
    end
  endtask

  task automatic test_stall();
    logic [31:0] b0, m0;
    b0 = m_br_cnt;
    m0 = m_mis_cnt;
    if_pc = 32'h400;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, BR_JAL, 32'h400, 32'h0, 32'h0, 32'h80, 0, 32'h404);
      n_checks++;
      if (redirect !== 1'b0 || redirect_pc !== 32'h404) begin
        n_errors++; $display("FAIL stall_hold_%0d: got redirect=%0b pc=%h expected 0 00000404", k, redirect, redirect_pc);
      end
      tick();
      n_checks++;
      if (br_count !== b0 || mispred_count !== m0) begin
        n_errors++; $display("FAIL stall_counts_%0d: got br=%0d mis=%0d expected %0d %0d", k, br_count, mispred_count, b0, m0);
      end
    end
    drive(1, 0, BR_JAL, 32'h400, 32'h0, 32'h0, 32'h80, 0, 32'h404);
    n_checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h480) begin
      n_errors++; $display("FAIL stall_release: got redirect=%0b pc=%h expected 1 00000480", redirect, redirect_pc);
    end
    tick();
    idle();
    tick();
    n_checks++;
    if (br_count !== b0 + 32'd1 || mispred_count !== m0 + 32'd1) begin
      n_errors++; $display("FAIL stall_single_update: got br=%0d mis=%0d expected %0d %0d", br_count, mispred_count, b0 + 1, m0 + 1);
    end
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h480) begin
      n_errors++; $display("FAIL stall_btb_write: got %0b %h expected 1 00000480", pred_taken, pred_target);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc, ipc;
    bit pt;
    logic [31:0] ptgt;
    for (int n = 0; n < 400; n++) begin
      pc  = 32'h1000 + 32'd4 * $urandom_range(0, 63);
      ipc = 32'h1000 + 32'd4 * $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) begin
        pt = model_pred_taken(pc);
        ptgt = model_pred_target(pc);
      end else begin
        pt = 1'($urandom_range(0, 1));
        ptgt = 32'h1000 + 32'd4 * $urandom_range(0, 127);
      end
      if_pc = ipc;
      drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 8)), pc,
            32'($urandom_range(0, 3)) - 32'd2, 32'($urandom_range(0, 3)) - 32'd2,
            32'($urandom_range(0, 63)) * 32'd4 - 32'h80, pt, ptgt);
      n_checks++;
      if (pred_taken !== model_pred_taken(ipc) || pred_target !== model_pred_target(ipc)) begin
        n_errors++; $display("FAIL rand_predict[%0d]: pc=%h got %0b %h expected %0b %h", n, ipc,
                             pred_taken, pred_target, model_pred_taken(ipc), model_pred_target(ipc));
      end
      n_checks++;
      if (redirect !== model_redirect() || redirect_pc !== model_redirect_pc()) begin
        n_errors++; $display("FAIL rand_resolve[%0d]: br=%0d got %0b %h expected %0b %h", n, ex_br,
                             redirect, redirect_pc, model_redirect(), model_redirect_pc());
      end
      tick();
      n_checks++;
      if (br_count !== m_br_cnt || mispred_count !== m_mis_cnt) begin
        n_errors++; $display("FAIL rand_counts[%0d]: got br=%0d mis=%0d expected %0d %0d", n,
                             br_count, mispred_count, m_br_cnt, m_mis_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    if_pc = 32'h400;
    drive(1, 0, BR_JAL, 32'h400, 32'h0, 32'h0, 32'h80, 1, 32'h480);
    tick();
    drive(1, 0, BR_JAL, 32'h400, 32'h0, 32'h0, 32'h80, 1, 32'h480);
    n_checks++;
    if (pred_taken !== 1'b1 || br_count === 32'd0) begin
      n_errors++; $display("FAIL midreset_pre: got pred=%0b br=%0d expected 1 nonzero", pred_taken, br_count);
    end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h404) begin
      n_errors++; $display("FAIL midreset_btb: got %0b %h expected 0 00000404", pred_taken, pred_target);
    end
    n_checks++;
    if (br_count !== 32'd0 || mispred_count !== 32'd0) begin
      n_errors++; $display("FAIL midreset_counts: got br=%0d mis=%0d expected 0 0", br_count, mispred_count);
    end
    model_reset();
    @(posedge clk);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0 || br_count !== 32'd0) begin
      n_errors++; $display("FAIL midreset_no_pending: got pred=%0b br=%0d expected 0 0", pred_taken, br_count);
    end
  endtask

  initial begin
    test_reset();
    test_beq_train();
    test_signed_unsigned();
    test_jalr();
    test_stall();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
